// File: rtl/tff_counter_pkg.sv
// tff_counter_pkg: mode encodings shared by the counter and its users.
package tff_counter_pkg;
  typedef enum logic [1:0] {
    MODE_HOLD = 2'b00,
    MODE_UP   = 2'b01,
    MODE_DOWN = 2'b10,
    MODE_LOAD = 2'b11
  } mode_e;
endpackage

// File: rtl/tff_cell.sv
// tff_cell: single T flip-flop with synchronous active-high reset to 0.
module tff_cell (
  input  logic clk,
  input  logic rst,
  input  logic t,
  output logic q
);
  always_ff @(posedge clk) q <= rst ? 1'b0 : q ^ t;
endmodule

// File: rtl/tff_counter.sv
// tff_counter: modulus counter built from T flip-flop cells; next Q is always Q ^ t.
module tff_counter
  import tff_counter_pkg::*;
#(
  parameter int WIDTH    = 4,
  parameter int MAX_VAL  = 2**WIDTH-1,
  parameter int SATURATE = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [1:0]       mode,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] Q,
  output logic             tc,
  output logic             wrap
);
  localparam logic [WIDTH-1:0] MAX = WIDTH'(MAX_VAL);
  localparam bit SAT = SATURATE != 0;
  logic [WIDTH-1:0] t, up_t, dn_t, ld_v;
  logic at_max, at_min, wrap_d, wrap_q;
  assign up_t[0] = 1'b1;
  assign dn_t[0] = 1'b1;
  for (genvar g = 1; g < WIDTH; g++) begin : g_tog
    assign up_t[g] = &Q[g-1:0];
    assign dn_t[g] = ~|Q[g-1:0];
  end
  for (genvar g = 0; g < WIDTH; g++) begin : g_cell
    tff_cell u_cell (.clk(clk), .rst(rst), .t(t[g]), .q(Q[g]));
  end
  assign at_max = Q == MAX;
  assign at_min = Q == '0;
  assign ld_v   = load_val > MAX ? MAX : load_val;
  // At a bound, wrap toggles straight to the opposite bound; saturate freezes.
  always_comb begin
    t = !en                 ? '0 :
        mode == MODE_UP     ? (at_max ? (SAT ? '0 : Q) : up_t) :
        mode == MODE_DOWN   ? (at_min ? (SAT ? '0 : Q ^ MAX) : dn_t) :
        mode == MODE_LOAD   ? Q ^ ld_v : '0;
    tc     = en & ((mode == MODE_UP & at_max) | (mode == MODE_DOWN & at_min));
    wrap_d = tc & ~SAT;
  end
  always_ff @(posedge clk) wrap_q <= rst ? 1'b0 : wrap_d;
  assign wrap = wrap_q;
endmodule

// File: tb/tb_tff_counter.sv
// tb_tff_counter: three counter configurations driven in lockstep against an arithmetic model.
module tb_tff_counter;
  import tff_counter_pkg::*;
  logic clk = 0, rst = 1, en = 1;
  logic [1:0] mode = MODE_UP;
  logic [3:0] load_val = '0;
  logic [3:0] q [3];
  logic tc [3], wr [3];
  int n_cmp = 0, n_err = 0;
  bit valid = 0;
  int mq [3], mw [3];
  localparam int MX [3] = '{9, 9, 15};
  localparam int SATP [3] = '{0, 1, 0};
  always #5 clk = ~clk;
  tff_counter #(.WIDTH(4), .MAX_VAL(9), .SATURATE(0)) u0 (.clk(clk), .rst(rst), .en(en), .mode(mode),
    .load_val(load_val), .Q(q[0]), .tc(tc[0]), .wrap(wr[0]));
  tff_counter #(.WIDTH(4), .MAX_VAL(9), .SATURATE(1)) u1 (.clk(clk), .rst(rst), .en(en), .mode(mode),
    .load_val(load_val), .Q(q[1]), .tc(tc[1]), .wrap(wr[1]));
  tff_counter #(.WIDTH(4)) u2 (.clk(clk), .rst(rst), .en(en), .mode(mode),
    .load_val(load_val), .Q(q[2]), .tc(tc[2]), .wrap(wr[2]));
  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %0d expected %0d", nm, $time, act, exp);
    end
  endtask
  function automatic int mtc(int k);
    return int'(en && ((mode == MODE_UP && mq[k] == MX[k]) || (mode == MODE_DOWN && mq[k] == 0)));
  endfunction
  always @(posedge clk)
    for (int k = 0; k < 3; k++) begin
      automatic int t = mtc(k);
      automatic int nq = mq[k];
      if (rst) begin
        nq = 0;
        t = 0;
      end else if (en) begin
        case (mode)
          MODE_UP:   nq = mq[k] == MX[k] ? (SATP[k] ? mq[k] : 0) : mq[k] + 1;
          MODE_DOWN: nq = mq[k] == 0 ? (SATP[k] ? 0 : MX[k]) : mq[k] - 1;
          MODE_LOAD: nq = int'(load_val) > MX[k] ? MX[k] : int'(load_val);
          default:   nq = mq[k];
        endcase
      end
      mw[k] = int'(t != 0 && SATP[k] == 0);
      mq[k] = nq;
    end
  always @(negedge clk)
    if (valid)
      for (int k = 0; k < 3; k++) begin
        chk($sformatf("u%0d.Q", k), 32'(q[k]), 32'(mq[k]));
        chk($sformatf("u%0d.tc", k), 32'(tc[k]), 32'(mtc(k)));
        chk($sformatf("u%0d.wrap", k), 32'(wr[k]), 32'(mw[k]));
      end
  task automatic cyc(logic r, logic e, logic [1:0] m, logic [3:0] lv);
    rst = r;
    en = e;
    mode = m;
    load_val = lv;
    @(posedge clk);
    #1;
  endtask
  initial begin
    for (int i = 0; i < 3; i++) begin
      cyc(1, 1, MODE_UP, 0);
      chk("rst_q", 32'(q[0]), 0);
      chk("rst_wrap", 32'(wr[0]), 0);
    end
    valid = 1;
    cyc(0, 1, MODE_UP, 0);
    chk("first_count", 32'(q[0]), 1);
    for (int i = 2; i <= 9; i++) cyc(0, 1, MODE_UP, 0);
    chk("up_q9", 32'(q[0]), 9);
    chk("tc_at_9", 32'(tc[0]), 1);
    cyc(0, 1, MODE_UP, 0);
    chk("up_wrap_q", 32'(q[0]), 0);
    chk("up_wrap_pulse", 32'(wr[0]), 1);
    chk("sat_up_stick", 32'(q[1]), 9);
    chk("sat_up_nowrap", 32'(wr[1]), 0);
    cyc(1, 0, MODE_HOLD, 0);
    cyc(0, 1, MODE_DOWN, 0);
    chk("down_wrap_q", 32'(q[0]), 9);
    chk("down_wrap_pulse", 32'(wr[0]), 1);
    chk("down_wrap_q15", 32'(q[2]), 15);
    chk("sat_down_q", 32'(q[1]), 0);
    chk("sat_down_tc", 32'(tc[1]), 1);
    chk("sat_down_wrap", 32'(wr[1]), 0);
    cyc(0, 1, MODE_LOAD, 6);
    chk("load6", 32'(q[0]), 6);
    cyc(0, 1, MODE_LOAD, 13);
    chk("load13_clamp", 32'(q[0]), 9);
    chk("load13_noclamp", 32'(q[2]), 13);
    cyc(0, 1, MODE_LOAD, 9);
    chk("load_same", 32'(q[0]), 9);
    chk("load_nowrap", 32'(wr[0]), 0);
    cyc(0, 0, MODE_LOAD, 3);
    chk("load_en0_hold", 32'(q[0]), 9);
    cyc(0, 1, MODE_LOAD, 5);
    cyc(0, 1, MODE_UP, 0);
    chk("en_seq0", 32'(q[0]), 6);
    cyc(0, 0, MODE_UP, 0);
    chk("en_seq1", 32'(q[0]), 6);
    cyc(0, 1, MODE_UP, 0);
    chk("en_seq2", 32'(q[0]), 7);
    cyc(0, 0, MODE_UP, 0);
    chk("en_seq3", 32'(q[0]), 7);
    cyc(0, 1, MODE_HOLD, 0);
    chk("hold_q", 32'(q[0]), 7);
    chk("hold_tc", 32'(tc[0]), 0);
    cyc(0, 1, MODE_LOAD, 9);
    cyc(1, 1, MODE_UP, 0);
    chk("rst_over_wrap_q", 32'(q[0]), 0);
    chk("rst_over_wrap_w", 32'(wr[0]), 0);
    cyc(0, 0, MODE_HOLD, 0);
    chk("rst_over_wrap_w2", 32'(wr[0]), 0);
    cyc(0, 1, MODE_LOAD, 4);
    cyc(1, 1, MODE_LOAD, 7);
    chk("rst_over_load", 32'(q[0]), 0);
    for (int i = 0; i < 600; i++)
      cyc($urandom_range(0, 24) == 0, $urandom_range(0, 3) != 0, 2'($urandom), 4'($urandom));
    @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
